// File: rtl/input_debouncer.sv
// Input debouncer: synchronizes a raw asynchronous level, then qualifies each
// transition over a programmable stability window before updating level_o.
// Optional feature macro: INPUT_DEBOUNCER_GLITCH_COUNT_EN (saturating glitch counter).

package sys_structs;
  // Clock domain bundle: single clock, clock enable, synchronous active-high reset.
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;
endpackage

// Purpose: debounce async_i into level_o using a four-state qualify FSM.
// Latency: SYNC_STAGES + settle_cycles_i + 2 cycles from a clean step to level_o.
// Backpressure: none; free-running, advances only on clk_en edges (sync chain always shifts).
module input_debouncer #(
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int COUNT_WIDTH = 8
) (
  input  sys_structs::clk_domain  clk_dom_i,
  input  logic                    debounce_en_i,
  input  logic [COUNT_WIDTH-1:0]  settle_cycles_i,
  input  logic                    async_i,
  output logic                    level_o,
  output logic                    settling_o,
  output logic                    glitch_o,
  output logic [7:0]              glitch_count_o
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    SETTLE_HIGH = 2'd1,
    STABLE_HIGH = 2'd2,
    SETTLE_LOW  = 2'd3
  } state_e;

  logic clk;
  logic clk_en;
  logic sync_rst;

  assign clk      = clk_dom_i.clk;
  assign clk_en   = clk_dom_i.clk_en;
  assign sync_rst = clk_dom_i.sync_rst;

  // ---------------------------------------------------------------------------
  // Synchronizer chain: shifts on every edge so metastability settling time
  // does not depend on how sparse clk_en is.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync;

  // Next value of the shift chain: async_i enters at bit 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Synchronizer register, ignores clk_en.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Qualification FSM and settle counter.
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  state_e                 state_d;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic                   glitch_evt;

  // State and counter register, advancing only on enabled edges.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The >= compare lets a shrinking window end at once, and
  // the counter only increments while below the window, so it cannot wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_evt = 1'b0;
    if (!debounce_en_i) begin
      // Bypass: track sync directly and drop any qualification in flight
      // without reporting it as a glitch.
      state_d = sync ? STABLE_HIGH : STABLE_LOW;
    end else begin
      case (state_q)
        STABLE_LOW: begin
          if (sync) begin
            state_d = SETTLE_HIGH;
            cnt_d   = '0;
          end
        end
        SETTLE_HIGH: begin
          if (!sync) begin
            state_d    = STABLE_LOW;
            glitch_evt = 1'b1;
          end else if (cnt_q >= settle_cycles_i) begin
            state_d = STABLE_HIGH;
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
        STABLE_HIGH: begin
          if (!sync) begin
            state_d = SETTLE_LOW;
            cnt_d   = '0;
          end
        end
        SETTLE_LOW: begin
          if (sync) begin
            state_d    = STABLE_HIGH;
            glitch_evt = 1'b1;
          end else if (cnt_q >= settle_cycles_i) begin
            state_d = STABLE_LOW;
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, derived from the next state so they line up with it.
  // ---------------------------------------------------------------------------
  logic level_q;
  logic level_d;
  logic settling_q;
  logic settling_d;
  logic glitch_q;
  logic glitch_d;

  // Output decode: level follows the committed stable level (a SETTLE state
  // still reports the level it is leaving), settling marks SETTLE states.
  always_comb begin
    level_d    = level_q;
    settling_d = 1'b0;
    glitch_d   = glitch_evt;
    case (state_d)
      STABLE_LOW:  level_d = 1'b0;
      SETTLE_HIGH: begin
        level_d    = 1'b0;
        settling_d = 1'b1;
      end
      STABLE_HIGH: level_d = 1'b1;
      SETTLE_LOW: begin
        level_d    = 1'b1;
        settling_d = 1'b1;
      end
      default:     level_d = level_q;
    endcase
  end

  // Output register, advancing only on enabled edges.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      level_q    <= 1'b0;
      settling_q <= 1'b0;
      glitch_q   <= 1'b0;
    end else if (clk_en) begin
      level_q    <= level_d;
      settling_q <= settling_d;
      glitch_q   <= glitch_d;
    end
  end

  assign level_o    = level_q;
  assign settling_o = settling_q;
  assign glitch_o   = glitch_q;

  // ---------------------------------------------------------------------------
  // Optional saturating count of rejected transitions.
  // ---------------------------------------------------------------------------
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] gcnt_q;
  logic [7:0] gcnt_d;

  // Increment alongside each glitch pulse, holding at 255.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_evt && (gcnt_q != 8'hFF)) begin
      gcnt_d = gcnt_q + 8'd1;
    end
  end

  // Glitch counter register, advancing only on enabled edges.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      gcnt_q <= 8'd0;
    end else if (clk_en) begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_count_o = gcnt_q;
`else
  assign glitch_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (SYNC_STAGES=2, COUNT_WIDTH=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected glitch counts follow INPUT_DEBOUNCER_GLITCH_COUNT_EN when defined.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   clk_en;
  logic                   rst;
  sys_structs::clk_domain clk_dom;
  logic                   debounce_en;
  logic [7:0]             settle;
  logic                   async_in;
  logic                   level_o;
  logic                   settling_o;
  logic                   glitch_o;
  logic [7:0]             glitch_count_o;

  int n_pass  = 0;
  int n_total = 0;
  int exp_gc  = 0;

  assign clk_dom = '{clk: clk, clk_en: clk_en, sync_rst: rst};

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(2), .COUNT_WIDTH(8)) dut (
    .clk_dom_i       (clk_dom),
    .debounce_en_i   (debounce_en),
    .settle_cycles_i (settle),
    .async_i         (async_in),
    .level_o         (level_o),
    .settling_o      (settling_o),
    .glitch_o        (glitch_o),
    .glitch_count_o  (glitch_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; debounce_en = 1'b1; settle = 8'd5; async_in = 1'b0;
    tick(); tick();
    n_total++;
    if ({level_o, settling_o, glitch_o} !== 3'b000)
      $display("FAIL reset_outs got=%b exp=000", {level_o, settling_o, glitch_o});
    else n_pass++;
    n_total++;
    if (glitch_count_o !== 8'd0) $display("FAIL reset_gcnt got=%0d exp=0", glitch_count_o);
    else n_pass++;
    rst = 1'b0; clk_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_total++;
    if (level_o !== 1'b0) $display("FAIL reset_idle level got=%b exp=0", level_o);
    else n_pass++;
  endtask

  // Rising then falling clean step, settle=5: edge 9 changes level, 6 settling cycles.
  task automatic test_clean_step();
    int n_settle;
    settle = 8'd5; async_in = 1'b1; n_settle = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (settling_o === 1'b1) n_settle++;
      if (k == 8) begin
        n_total++;
        if (level_o !== 1'b0) $display("FAIL step_rise_early level got=%b exp=0", level_o);
        else n_pass++;
      end
    end
    n_total++;
    if (level_o !== 1'b1) $display("FAIL step_rise level got=%b exp=1", level_o);
    else n_pass++;
    n_total++;
    if (n_settle != 6) $display("FAIL step_settling cycles got=%0d exp=6", n_settle);
    else n_pass++;
    async_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) begin
        n_total++;
        if (level_o !== 1'b1) $display("FAIL step_fall_early level got=%b exp=1", level_o);
        else n_pass++;
      end
    end
    n_total++;
    if (level_o !== 1'b0) $display("FAIL step_fall level got=%b exp=0", level_o);
    else n_pass++;
  endtask

  // settle=0: exactly one enabled edge in SETTLE, level after edge 4.
  task automatic test_settle_zero();
    settle = 8'd0; async_in = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if ({level_o, settling_o} !== 2'b01)
      $display("FAIL zero_settle_e3 lvl_settling got=%b exp=01", {level_o, settling_o});
    else n_pass++;
    tick();
    n_total++;
    if ({level_o, settling_o} !== 2'b10)
      $display("FAIL zero_settle_e4 lvl_settling got=%b exp=10", {level_o, settling_o});
    else n_pass++;
    async_in = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    settle = 8'd5;
  endtask

  // High for 3 cycles with settle=5: rejected at edge 6.
  task automatic test_bounce();
    int n_glitch;
    int glitch_at;
    bit saw_high;
    n_glitch = 0; glitch_at = -1; saw_high = 1'b0;
    async_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) async_in = 1'b0;
      if (glitch_o === 1'b1) begin n_glitch++; glitch_at = k; end
      if (level_o !== 1'b0) saw_high = 1'b1;
    end
    exp_gc = GC_EN ? exp_gc + 1 : 0;
    n_total++;
    if (n_glitch != 1) $display("FAIL bounce_pulses got=%0d exp=1", n_glitch);
    else n_pass++;
    n_total++;
    if (glitch_at != 6) $display("FAIL bounce_pulse_edge got=%0d exp=6", glitch_at);
    else n_pass++;
    n_total++;
    if (saw_high) $display("FAIL bounce_level got=1 exp=0");
    else n_pass++;
    n_total++;
    if (glitch_count_o !== 8'(exp_gc))
      $display("FAIL bounce_gcnt got=%0d exp=%0d", glitch_count_o, exp_gc);
    else n_pass++;
  endtask

  // Bypass: level follows sync one edge later, i.e. 3 cycles after the step.
  task automatic test_bypass();
    bit saw_settle;
    saw_settle = 1'b0;
    debounce_en = 1'b0; async_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (settling_o !== 1'b0) saw_settle = 1'b1;
      if (k == 2) begin
        n_total++;
        if (level_o !== 1'b0) $display("FAIL bypass_rise_early level got=%b exp=0", level_o);
        else n_pass++;
      end
    end
    n_total++;
    if (level_o !== 1'b1) $display("FAIL bypass_rise level got=%b exp=1", level_o);
    else n_pass++;
    async_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (settling_o !== 1'b0) saw_settle = 1'b1;
    end
    n_total++;
    if (level_o !== 1'b0) $display("FAIL bypass_fall level got=%b exp=0", level_o);
    else n_pass++;
    n_total++;
    if (saw_settle) $display("FAIL bypass_settling got=1 exp=0");
    else n_pass++;
    debounce_en = 1'b1;
  endtask

  // Drop debounce_en mid-settle: no glitch, level jumps to sync, state stays high.
  task automatic test_abort();
    settle = 8'd10; async_in = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    n_total++;
    if (settling_o !== 1'b1) $display("FAIL abort_pre settling got=%b exp=1", settling_o);
    else n_pass++;
    debounce_en = 1'b0;
    tick();
    n_total++;
    if ({level_o, settling_o, glitch_o} !== 3'b100)
      $display("FAIL abort_outs got=%b exp=100", {level_o, settling_o, glitch_o});
    else n_pass++;
    debounce_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_total++;
    if ({level_o, settling_o} !== 2'b10)
      $display("FAIL abort_hold lvl_settling got=%b exp=10", {level_o, settling_o});
    else n_pass++;
    n_total++;
    if (glitch_count_o !== 8'(exp_gc))
      $display("FAIL abort_gcnt got=%0d exp=%0d", glitch_count_o, exp_gc);
    else n_pass++;
    debounce_en = 1'b0; async_in = 1'b0;
    tick(); tick(); tick();
    debounce_en = 1'b1;
  endtask

  // Shrink the window mid-settle: cnt=3 >= 2 ends qualification next edge.
  task automatic test_settle_shrink();
    settle = 8'd10; async_in = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    n_total++;
    if (level_o !== 1'b0) $display("FAIL shrink_pre level got=%b exp=0", level_o);
    else n_pass++;
    settle = 8'd2;
    tick();
    n_total++;
    if ({level_o, settling_o} !== 2'b10)
      $display("FAIL shrink_done lvl_settling got=%b exp=10", {level_o, settling_o});
    else n_pass++;
    settle = 8'd3; async_in = 1'b0;
    for (int k = 0; k < 10; k++) tick();
  endtask

  // clk_en on odd edges only, settle=3: level rises on the 5th enabled edge
  // after sync goes high (edges 3,5,7,9,11).
  task automatic test_clk_en();
    settle = 8'd3; async_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      clk_en = k[0];
      tick();
      if (k == 3) begin
        n_total++;
        if (settling_o !== 1'b1) $display("FAIL gate_settle_start settling got=%b exp=1", settling_o);
        else n_pass++;
      end
      if (k == 10) begin
        n_total++;
        if (level_o !== 1'b0) $display("FAIL gate_e10 level got=%b exp=0", level_o);
        else n_pass++;
      end
      if (k == 11) begin
        n_total++;
        if (level_o !== 1'b1) $display("FAIL gate_e11 level got=%b exp=1", level_o);
        else n_pass++;
      end
    end
    clk_en = 1'b1;
  endtask

  // Reset during SETTLE_HIGH (clk_en low), then re-qualify the still-high input.
  task automatic test_reset_mid_settle();
    settle = 8'd5; async_in = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    async_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_total++;
    if (settling_o !== 1'b1) $display("FAIL rst_mid_pre settling got=%b exp=1", settling_o);
    else n_pass++;
    rst = 1'b1; clk_en = 1'b0;
    tick();
    exp_gc = 0;
    n_total++;
    if ({level_o, settling_o, glitch_o} !== 3'b000 || glitch_count_o !== 8'd0)
      $display("FAIL rst_mid_outs got=%b/%0d exp=000/0", {level_o, settling_o, glitch_o}, glitch_count_o);
    else n_pass++;
    rst = 1'b0; clk_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) begin
        n_total++;
        if (level_o !== 1'b0) $display("FAIL rst_release_early level got=%b exp=0", level_o);
        else n_pass++;
      end
    end
    n_total++;
    if (level_o !== 1'b1) $display("FAIL rst_release_rise level got=%b exp=1", level_o);
    else n_pass++;
    async_in = 1'b0;
    for (int k = 0; k < 10; k++) tick();
  endtask

  // 300 one-cycle pulses, each rejected; counter saturates at 255.
  task automatic test_saturation();
    int n_glitch;
    bit saw_high;
    n_glitch = 0; saw_high = 1'b0; settle = 8'd5;
    for (int i = 0; i < 300; i++) begin
      async_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        async_in = 1'b0;
        if (glitch_o === 1'b1) n_glitch++;
        if (level_o !== 1'b0) saw_high = 1'b1;
      end
    end
    exp_gc = GC_EN ? ((exp_gc + 300 > 255) ? 255 : exp_gc + 300) : 0;
    n_total++;
    if (n_glitch != 300) $display("FAIL sat_pulses got=%0d exp=300", n_glitch);
    else n_pass++;
    n_total++;
    if (saw_high) $display("FAIL sat_level got=1 exp=0");
    else n_pass++;
    n_total++;
    if (glitch_count_o !== 8'(exp_gc))
      $display("FAIL sat_gcnt got=%0d exp=%0d", glitch_count_o, exp_gc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_settle_zero();
    test_bounce();
    test_bypass();
    test_abort();
    test_settle_shrink();
    test_clk_en();
    test_reset_mid_settle();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on async_i (legal range 2..4).
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, width of the settle counter and settle_cycles_i.
REQ-003 SHALL have port clk_dom_i, input, sys_structs::clk_domain, carrying clk (single clock), clk_en and sync_rst (synchronous, active-high reset).
REQ-004 SHALL have port debounce_en_i, input, 1, where 1 enables filtering and 0 selects synchronized bypass.
REQ-005 SHALL have port settle_cycles_i, input, COUNT_WIDTH, the stability window in enabled cycles.
REQ-006 SHALL have port async_i, input, 1, raw asynchronous level (pin or button).
REQ-007 SHALL have port level_o, output, 1, registered debounced level, intended to drive monostable_full sense_i.
REQ-008 SHALL have port settling_o, output, 1, high while a candidate transition is being qualified.
REQ-009 SHALL have port glitch_o, output, 1, one-enabled-cycle pulse when a candidate transition is rejected.
REQ-010 SHALL have port glitch_count_o, output, 8, count of rejected transitions (see Configuration).

Function
REQ-011 Synchronizer flops SHALL shift on every clk edge regardless of clk_en; the final stage is "sync".
REQ-012 The FSM, counter and all outputs SHALL advance only on clk edges with clk_en=1 ("enabled edge").
REQ-013 FSM states SHALL be STABLE_LOW, SETTLE_HIGH, STABLE_HIGH and SETTLE_LOW.
REQ-014 In STABLE_LOW with sync=1, or STABLE_HIGH with sync=0, the FSM SHALL enter the matching SETTLE state and clear the counter to 0.
REQ-015 In SETTLE_x, if sync reverts, the FSM SHALL return to the prior STABLE state and pulse glitch_o for that enabled edge; level_o is unchanged.
REQ-016 In SETTLE_x with sync held, if counter >= settle_cycles_i the FSM SHALL enter STABLE_x and update level_o; otherwise the counter SHALL increment.
REQ-017 The >= compare SHALL be used so that a reduction of settle_cycles_i mid-settle terminates on the next enabled edge; the counter never wraps.
REQ-018 With clk_en held 1 and debounce_en_i=1, a clean step on async_i SHALL appear on level_o exactly SYNC_STAGES+settle_cycles_i+2 clk cycles later.
REQ-019 settle_cycles_i=0 SHALL give exactly one enabled edge in the SETTLE state.
REQ-020 settling_o SHALL be 1 exactly when the state is SETTLE_HIGH or SETTLE_LOW.
REQ-021 With debounce_en_i=0, each enabled edge SHALL set level_o=sync and force the state to STABLE_LOW or STABLE_HIGH to match sync; settling_o=0 and glitch_o=0.
REQ-022 Deasserting debounce_en_i mid-settle SHALL abort qualification without a glitch pulse.
REQ-023 level_o, settling_o and glitch_o SHALL all be registered outputs.

Reset
REQ-024 sync_rst SHALL act regardless of clk_en.
REQ-025 On sync_rst, synchronizer flops=0, state=STABLE_LOW, counter=0, level_o=0, settling_o=0, glitch_o=0 and glitch_count_o=0.
REQ-026 If async_i is high when reset releases, level_o SHALL rise only via the normal settle path.

Configuration
REQ-027 With macro INPUT_DEBOUNCER_GLITCH_COUNT_EN defined, glitch_count_o SHALL increment by one on each glitch_o pulse and saturate at 255.
REQ-028 Without INPUT_DEBOUNCER_GLITCH_COUNT_EN, glitch_count_o SHALL be tied to constant 0 and no counter register SHALL be synthesized.

Verification
REQ-029 Clean step: clk_en=1, SYNC_STAGES=2, settle=5; async_i steps 0->1 -> level_o rises exactly 9 cycles later, settling_o high for 6 cycles.
REQ-030 Bounce rejection: settle=5; async_i high for 3 cycles then low -> level_o stays 0, one glitch_o pulse, glitch_count_o=1 when the macro is defined.
REQ-031 Bypass mode: debounce_en_i=0; async_i 0->1 -> level_o rises 3 cycles later (SYNC_STAGES+1), settling_o=0 throughout.
REQ-032 Clock-enable gating: clk_en toggling 1/0 with settle=3 -> only enabled edges count, and level_o rises after 5 enabled edges following sync.
REQ-033 Reset mid-settle: sync_rst asserted during SETTLE_HIGH -> next cycle all outputs=0, state=STABLE_LOW.
REQ-034 Saturation: 300 rejected glitches with the macro defined -> glitch_count_o=255.
